// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types for the VGA rectangle fill engine: coordinate
//                and colour types, the rectangle command record and the fill
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int c_coord_w = 10;
  localparam int c_color_w = 3;

  typedef logic [c_coord_w-1:0] coord_t;
  typedef logic [c_color_w-1:0] color_t;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t w;
    coord_t h;
    color_t color;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync2
//  Description : Two-flop synchroniser for a single level signal crossing
//                into the clk domain; both flops clear on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync2 (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous level through two flops to settle metastability
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rect_fill
//  Description : Command-driven rectangle fill engine. Accepts one rectangle
//                command over valid/ready and emits one row-major framebuffer
//                write per cycle. Writes can be held off while the display is
//                in its visible region (tear_free).
//                Optional clipping to width/height: VGA_RECT_FILL_CLIP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int COORD_W = c_coord_w,
  parameter int COLOR_W = c_color_w
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  input  logic               tear_free,
  input  logic               visible,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic [COLOR_W-1:0] pixel,
  output logic               wr_en,
  output logic               busy,
  output logic               done
);

  localparam logic [COORD_W-1:0] c_one = {{(COORD_W-1){1'b0}}, 1'b1};

  fill_state_e        r_state;
  logic [COORD_W-1:0] r_x0, r_y0, r_w, r_h;
  logic [COLOR_W-1:0] r_color;
  logic [COORD_W-1:0] r_ew, r_eh;
  logic [COORD_W-1:0] r_cx, r_cy, r_cols, r_rows;
  // Set once the final pixel has been written (or the extent is empty);
  // the next FILL cycle then raises done, so done always trails the last write.
  logic               r_last;

  logic               w_vis_s;
  logic               w_stall;
  logic [COORD_W-1:0] w_ew, w_eh;

  vga_sync2 u_vis_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (visible),
    .q      (w_vis_s)
  );

  assign w_stall = tear_free & w_vis_s;

`ifdef VGA_RECT_FILL_CLIP_EN
  logic [COORD_W-1:0] w_room_x, w_room_y;

  // Clip the latched extent to the active area so no write lands outside it
  always_comb begin
    w_room_x = width - r_x0;
    w_room_y = height - r_y0;
    w_ew     = '0;
    w_eh     = '0;
    if (r_x0 < width) begin
      w_ew = (r_w < w_room_x) ? r_w : w_room_x;
    end
    if (r_y0 < height) begin
      w_eh = (r_h < w_room_y) ? r_h : w_room_y;
    end
  end
`else
  // Unclipped: the framebuffer handles anything beyond the active area
  logic w_unused;
  assign w_unused = ^{width, height};
  assign w_ew     = r_w;
  assign w_eh     = r_h;
`endif

  // Fill FSM with all outputs registered
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
      r_ew      <= '0;
      r_eh      <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_cols    <= '0;
      r_rows    <= '0;
      r_last    <= 1'b0;
      X         <= '0;
      Y         <= '0;
      pixel     <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_x0      <= cmd_x0;
            r_y0      <= cmd_y0;
            r_w       <= cmd_w;
            r_h       <= cmd_h;
            r_color   <= cmd_color;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_ew    <= w_ew;
            r_eh    <= w_eh;
            r_cx    <= r_x0;
            r_cy    <= r_y0;
            r_cols  <= '0;
            r_rows  <= '0;
            // Empty rectangle: skip straight to the completion pulse
            r_last  <= (w_ew == '0) || (w_eh == '0);
            r_state <= FILL;
          end
        end
        FILL: begin
          if (abort) begin
            r_last    <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end else if (r_last) begin
            r_last  <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else if (!w_stall) begin
            wr_en <= 1'b1;
            X     <= r_cx;
            Y     <= r_cy;
            pixel <= r_color;
            if (r_cols == r_ew - c_one) begin
              r_cx   <= r_x0;
              r_cols <= '0;
              if (r_rows == r_eh - c_one) begin
                r_last <= 1'b1;
              end else begin
                r_cy   <= r_cy + c_one;
                r_rows <= r_rows + c_one;
              end
            end else begin
              r_cx   <= r_cx + c_one;
              r_cols <= r_cols + c_one;
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_rect_fill
//  Description : Directed self-checking bench for vga_rect_fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rect_fill;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic [2:0] cmd_color = '0;
  logic       abort = 1'b0;
  logic       tear_free = 1'b0;
  logic       visible = 1'b0;
  logic [9:0] width = 10'd640;
  logic [9:0] height = 10'd480;
  logic [9:0] X, Y;
  logic [2:0] pixel;
  logic       wr_en, busy, done;

  int checks = 0;
  int failures = 0;

  vga_rect_fill dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .abort     (abort),
    .tear_free (tear_free),
    .visible   (visible),
    .width     (width),
    .height    (height),
    .X         (X),
    .Y         (Y),
    .pixel     (pixel),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Per-run capture, indexed by clock edges since command acceptance (k=0)
  int         wr_k[$];
  logic [9:0] wr_x[$], wr_y[$];
  logic [2:0] wr_p[$];
  int         done_k, done_cnt;
  logic       rdy_at[64], busy_at[64], wen_at[64];
  logic [9:0] x_at[64], y_at[64];
  logic [2:0] p_at[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge, hold until accepted, return at negedge k=0
  task automatic send(input logic [9:0] x0, y0, w, h, input logic [2:0] c);
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    for (int t = 0; t < 50 && !cmd_ready; t++) @(negedge clk);
    if (!cmd_ready) chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Sample outputs for k=0..maxk, optionally toggling visible and raising abort
  task automatic collect(input int maxk, input int vis_on, input int vis_off, input int abort_n);
    bit aborted;
    aborted = 1'b0;
    wr_k.delete(); wr_x.delete(); wr_y.delete(); wr_p.delete();
    done_k = -1;
    done_cnt = 0;
    for (int k = 0; k <= maxk; k++) begin
      wen_at[k] = wr_en; rdy_at[k] = cmd_ready; busy_at[k] = busy;
      x_at[k] = X; y_at[k] = Y; p_at[k] = pixel;
      if (wr_en === 1'b1) begin
        wr_k.push_back(k); wr_x.push_back(X); wr_y.push_back(Y); wr_p.push_back(pixel);
      end
      if (done === 1'b1) begin
        if (done_k < 0) done_k = k;
        done_cnt++;
      end
      abort = 1'b0;
      if (!aborted && abort_n > 0 && wr_x.size() == abort_n) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      if (k == vis_on) visible = 1'b1;
      if (k == vis_off) visible = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int ex[6];
    int ey[6];
    ex = '{2, 3, 4, 2, 3, 4};
    ey = '{3, 3, 3, 4, 4, 4};

    // ---- reset state
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_X", 32'(X), 32'd0);
    chk("rst_Y", 32'(Y), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    arst_n = 1'b1;
    @(negedge clk);

    // ---- basic 3x2 fill at (2,3), colour 5
    send(10'd2, 10'd3, 10'd3, 10'd2, 3'd5);
    collect(12, -1, -1, 0);
    chk("basic_busy_k0", 32'(busy_at[0]), 32'd1);
    chk("basic_ready_k0", 32'(rdy_at[0]), 32'd0);
    chk("basic_nwr", 32'(wr_x.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("basic_k_%0d", i), (wr_k.size() > i) ? 32'(wr_k[i]) : 32'hFFFF, 32'(2 + i));
      chk($sformatf("basic_x_%0d", i), (wr_x.size() > i) ? 32'(wr_x[i]) : 32'hFFFF, 32'(ex[i]));
      chk($sformatf("basic_y_%0d", i), (wr_y.size() > i) ? 32'(wr_y[i]) : 32'hFFFF, 32'(ey[i]));
      chk($sformatf("basic_p_%0d", i), (wr_p.size() > i) ? 32'(wr_p[i]) : 32'hFFFF, 32'd5);
    end
    chk("basic_done_k", 32'(done_k), 32'd8);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_ready_at_done", 32'(rdy_at[8]), 32'd0);
    chk("basic_busy_at_done", 32'(busy_at[8]), 32'd1);
    chk("basic_ready_after", 32'(rdy_at[9]), 32'd1);
    chk("basic_busy_after", 32'(busy_at[9]), 32'd0);
    chk("basic_hold_X", 32'(x_at[9]), 32'd4);
    chk("basic_hold_Y", 32'(y_at[9]), 32'd4);
    chk("basic_hold_pixel", 32'(p_at[9]), 32'd5);

    // ---- zero-width rectangle
    send(10'd5, 10'd5, 10'd0, 10'd4, 3'd1);
    collect(8, -1, -1, 0);
    chk("zero_nwr", 32'(wr_x.size()), 32'd0);
    chk("zero_done_k", 32'(done_k), 32'd2);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);

    // ---- tear-free stall on a 4x1 fill at (10,20)
    tear_free = 1'b1;
    send(10'd10, 10'd20, 10'd4, 10'd1, 3'd6);
    collect(22, 2, 12, 0);
    chk("tear_nwr", 32'(wr_x.size()), 32'd4);
    chk("tear_k0", (wr_k.size() > 0) ? 32'(wr_k[0]) : 32'hFFFF, 32'd2);
    chk("tear_k2", (wr_k.size() > 2) ? 32'(wr_k[2]) : 32'hFFFF, 32'd4);
    chk("tear_k3_resume", (wr_k.size() > 3) ? 32'(wr_k[3]) : 32'hFFFF, 32'd15);
    chk("tear_wen_stalled", 32'(wen_at[5]), 32'd0);
    chk("tear_x3", (wr_x.size() > 3) ? 32'(wr_x[3]) : 32'hFFFF, 32'd13);
    chk("tear_x2", (wr_x.size() > 2) ? 32'(wr_x[2]) : 32'hFFFF, 32'd12);
    chk("tear_y3", (wr_y.size() > 3) ? 32'(wr_y[3]) : 32'hFFFF, 32'd20);
    chk("tear_done_k", 32'(done_k), 32'd16);
    tear_free = 1'b0;

    // ---- abort after the third write of an 8x8 fill
    send(10'd0, 10'd0, 10'd8, 10'd8, 3'd3);
    collect(14, -1, -1, 3);
    chk("abort_nwr", 32'(wr_x.size()), 32'd3);
    chk("abort_wen_k5", 32'(wen_at[5]), 32'd0);
    chk("abort_ready_k5", 32'(rdy_at[5]), 32'd1);
    chk("abort_busy_k5", 32'(busy_at[5]), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    send(10'd0, 10'd0, 10'd1, 10'd1, 3'd7);
    collect(8, -1, -1, 0);
    chk("post_abort_nwr", 32'(wr_x.size()), 32'd1);
    chk("post_abort_x", (wr_x.size() > 0) ? 32'(wr_x[0]) : 32'hFFFF, 32'd0);
    chk("post_abort_y", (wr_y.size() > 0) ? 32'(wr_y[0]) : 32'hFFFF, 32'd0);
    chk("post_abort_p", (wr_p.size() > 0) ? 32'(wr_p[0]) : 32'hFFFF, 32'd7);
    chk("post_abort_done_k", 32'(done_k), 32'd3);

    // ---- rectangle straddling the bottom-right corner of a 640x480 area
    send(10'd638, 10'd479, 10'd5, 10'd3, 3'd2);
    collect(24, -1, -1, 0);
`ifdef VGA_RECT_FILL_CLIP_EN
    chk("clip_nwr", 32'(wr_x.size()), 32'd2);
    chk("clip_x0", (wr_x.size() > 0) ? 32'(wr_x[0]) : 32'hFFFF, 32'd638);
    chk("clip_x1", (wr_x.size() > 1) ? 32'(wr_x[1]) : 32'hFFFF, 32'd639);
    chk("clip_y1", (wr_y.size() > 1) ? 32'(wr_y[1]) : 32'hFFFF, 32'd479);
    chk("clip_done_k", 32'(done_k), 32'd4);
`else
    chk("noclip_nwr", 32'(wr_x.size()), 32'd15);
    chk("noclip_last_x", (wr_x.size() > 14) ? 32'(wr_x[14]) : 32'hFFFF, 32'd642);
    chk("noclip_last_y", (wr_y.size() > 14) ? 32'(wr_y[14]) : 32'hFFFF, 32'd481);
    chk("noclip_done_k", 32'(done_k), 32'd17);
`endif

    // ---- asynchronous reset in the middle of a fill
    send(10'd0, 10'd0, 10'd8, 10'd8, 3'd4);
    collect(5, -1, -1, 0);
    chk("rstmid_pre_nwr", 32'(wr_x.size()), 32'd4);
    #2 arst_n = 1'b0;
    #1;
    chk("rstmid_wr_en", 32'(wr_en), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    arst_n = 1'b1;
    collect(20, -1, -1, 0);
    chk("rstmid_post_nwr", 32'(wr_x.size()), 32'd0);
    chk("rstmid_post_done", 32'(done_cnt), 32'd0);
    chk("rstmid_post_busy", 32'(busy_at[20]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Command-driven rectangle fill engine sitting directly upstream of the VGA framebuffer block.
- Accepts one rectangle command at a time (origin, size, 3-bit colour) over a valid/ready handshake.
- Emits one framebuffer write per cycle on X/Y/pixel/wr_en, row-major.
- Optionally stalls writes while the display is in its visible region, giving tear-free updates.

Parameters:
- COORD_W, 10, coordinate width in bits; matches the framebuffer's 10-bit X/Y.
- COLOR_W, 3, pixel colour width in bits.

Ports:
- clk  in  1  system clock; same clock as the framebuffer write port.
- arst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- cmd_x0  in  COORD_W  rectangle left edge.
- cmd_y0  in  COORD_W  rectangle top edge.
- cmd_w  in  COORD_W  width in pixels; 0 is legal and means an empty rectangle.
- cmd_h  in  COORD_W  height in pixels; 0 is legal.
- cmd_color  in  COLOR_W  fill colour.
- abort  in  1  cancel the fill in progress.
- tear_free  in  1  when 1, writes are held off while visible is high.
- visible  in  1  framebuffer visible flag from the vclk domain; asynchronous to clk.
- width  in  COORD_W  active framebuffer width.
- height  in  COORD_W  active framebuffer height.
- X  out  COORD_W  write column.
- Y  out  COORD_W  write row.
- pixel  out  COLOR_W  write colour.
- wr_en  out  1  write strobe.
- busy  out  1  high from command acceptance until return to IDLE.
- done  out  1  one-cycle pulse when a fill completes normally.

Behaviour:
- Reset values:
  - wr_en=0, done=0, busy=0, X=0, Y=0, pixel=0, cmd_ready=1.
  - FSM=IDLE; visible synchroniser flops cleared to 0.
- visible is passed through a 2-flop synchroniser (vis_s).
  - stall = tear_free & vis_s.
- FSM IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch all cmd_* fields and go to LOAD. busy rises in the same edge.
- FSM LOAD (1 cycle):
  - Compute effective extents ew and eh (see Optional Feature).
  - If ew==0 or eh==0, go to DONE.
  - Otherwise set cx=x0, cy=y0, cols=0, rows=0, and go to FILL.
- FSM FILL, each cycle with !stall:
  - Drive wr_en=1, X=cx, Y=cy, pixel=colour.
  - Advance cx, with cols counting up to ew-1.
  - At the end of a row, reset cx=x0, cols=0, and advance cy/rows.
  - After the last pixel (cols==ew-1 & rows==eh-1), go to DONE.
- FILL with stall:
  - wr_en=0, counters hold.
  - Resumes on the first cycle stall drops.
- FSM DONE:
  - done=1 for one cycle.
  - Next state IDLE, where busy=0 and cmd_ready=1.
- Latency:
  - Command accepted at edge N, first wr_en at edge N+2 if not stalled.
  - A w×h unstalled fill asserts wr_en for exactly w*h consecutive cycles.
  - done is asserted in the cycle after the last wr_en.
- Coordinate arithmetic: cx and cy are COORD_W wide and wrap modulo 2^COORD_W.
- cmd_ready=0 in LOAD, FILL and DONE. cmd_valid in those states is ignored and not accepted.
- abort:
  - In LOAD or FILL, abort goes to IDLE at the next edge with no done pulse. wr_en is 0 from that edge on.
  - abort takes priority over stall and over last-pixel completion.
  - abort in IDLE or DONE has no effect.
  - abort together with cmd_valid in IDLE: the command is accepted.
- Asynchronous reset mid-fill: all outputs return to reset values immediately, and the command is lost.
- width and height are sampled in LOAD only. Changes during FILL have no effect on the current command.
- When wr_en=0, X, Y and pixel hold their last values.

Optional Feature:
- Macro: VGA_RECT_FILL_CLIP_EN.
- Defined:
  - ew = (x0>=width) ? 0 : min(w, width-x0).
  - eh = (y0>=height) ? 0 : min(h, height-y0).
  - No write is ever issued outside the active area.
- Undefined:
  - ew=w, eh=h.
  - Coordinates wrap modulo 2^COORD_W.
  - Writes beyond width/height are issued as-is; the framebuffer is responsible for them.

Decomposition:
- Package vga_pkg:
  - coord_t (COORD_W logic), color_t (COLOR_W logic).
  - rect_cmd_t struct {x0, y0, w, h, color}.
  - fill_state_e enum {IDLE, LOAD, FILL, DONE}.
- Sub-module: vga_sync2 (2-flop synchroniser with async active-low reset), used for visible. Reusable by other vclk→clk crossings.
- Extent clipping stays inline.

Test Plan:
- Basic fill: cmd x0=2, y0=3, w=3, h=2, colour=5, tear_free=0.
  - 6 writes, (2,3)(3,3)(4,3)(2,4)(3,4)(4,4), pixel=5.
  - First wr_en 2 cycles after acceptance; done 1 cycle after the last write; cmd_ready high the cycle after done.
- Zero size: w=0, h=4.
  - No wr_en; done 2 cycles after acceptance.
- Tear-free stall: tear_free=1, visible high for 10 cycles mid-fill of a 4×1 rectangle.
  - wr_en low from 2 cycles after visible rises to 2 cycles after it falls.
  - Exactly 4 writes total, no duplicates.
- Abort: abort after the 3rd write of an 8×8 fill.
  - wr_en=0 from the next edge; no done pulse; cmd_ready=1.
  - A following 1×1 cmd at (0,0) writes correctly.
- Clip (VGA_RECT_FILL_CLIP_EN): width=640, height=480, cmd x0=638, y0=479, w=5, h=3.
  - Exactly 2 writes, (638,479) and (639,479).
- Reset mid-fill: drop arst_n during FILL.
  - wr_en, busy and done are 0 immediately, cmd_ready=1; no further writes after release.
